// File: rtl/note_track_scheduler.sv
// Two-lane scrolling note field for the 16x2 LCD: fetches chart entries over req/ack,
// shifts both lanes left one column per scroll tick and reports the code leaving column 0.
module note_track_scheduler #(
    parameter int COLS     = 16,
    parameter int TICK_DIV = 2500000,
    parameter int ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pause,
    output logic              chart_req,
    output logic [ADDR_W-1:0] chart_addr,
    input  logic              chart_ack,
    input  logic [4:0]        chart_data,
    output logic [COLS-1:0]   noteup_bit0,
    output logic [COLS-1:0]   noteup_bit1,
    output logic [COLS-1:0]   notedown_bit0,
    output logic [COLS-1:0]   notedown_bit1,
    output logic              head_valid,
    output logic [1:0]        head_up,
    output logic [1:0]        head_down,
    output logic              busy,
    output logic              done,
    output logic              underrun
);
    // state     | meaning
    // S_IDLE    | waiting for start after reset
    // S_FETCH   | chart_req high, waiting for chart_ack
    // S_WAIT_TICK | entry staged, waiting for the scroll tick
    // S_SHIFT   | one-cycle scroll of both lanes
    // S_DONE    | chart ended and field drained
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT_TICK, S_SHIFT, S_DONE} state_t;

    localparam int               CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        stg_up, stg_dn;
    logic              pending, end_seen, underrun_q;
    logic [COLS-1:0]   up0, up1, dn0, dn1;
    logic [COLS-1:0]   up0_sh, up1_sh, dn0_sh, dn1_sh;
    logic              running, tick, end_now, field_empty;

    assign running = (state == S_FETCH) || (state == S_WAIT_TICK) || (state == S_SHIFT);
    assign tick    = running && !pause && (cnt == CNT_LAST);

    assign up0_sh = {stg_up[0], up0[COLS-1:1]};
    assign up1_sh = {stg_up[1], up1[COLS-1:1]};
    assign dn0_sh = {stg_dn[0], dn0[COLS-1:1]};
    assign dn1_sh = {stg_dn[1], dn1[COLS-1:1]};
    assign field_empty = ~|{up0_sh, up1_sh, dn0_sh, dn1_sh};

    // The shift that lands on the last address also ends the chart.
    assign end_now = end_seen || (addr == ADDR_MAX - 1'b1);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_next = S_FETCH;
            S_FETCH:        if (chart_ack) state_next = (pending || tick) ? S_SHIFT : S_WAIT_TICK;
            S_WAIT_TICK:    if (pending || tick) state_next = S_SHIFT;
            S_SHIFT: begin
                if (!end_now)        state_next = S_FETCH;
                else if (field_empty) state_next = S_DONE;
                else                  state_next = S_WAIT_TICK;
            end
            default:        state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            addr       <= '0;
            stg_up     <= '0;
            stg_dn     <= '0;
            pending    <= 1'b0;
            end_seen   <= 1'b0;
            underrun_q <= 1'b0;
            up0        <= '0;
            up1        <= '0;
            dn0        <= '0;
            dn1        <= '0;
        end else begin
            state <= state_next;
            if (running && !pause) cnt <= tick ? '0 : cnt + 1'b1;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        cnt        <= '0;
                        addr       <= '0;
                        stg_up     <= '0;
                        stg_dn     <= '0;
                        pending    <= 1'b0;
                        end_seen   <= 1'b0;
                        underrun_q <= 1'b0;
                        up0        <= '0;
                        up1        <= '0;
                        dn0        <= '0;
                        dn1        <= '0;
                    end
                end
                S_FETCH: begin
                    if (tick && pending) underrun_q <= 1'b1;
                    if (chart_ack) begin
                        pending <= 1'b0;
                        if (chart_data[4]) begin
                            end_seen <= 1'b1;
                            stg_up   <= '0;
                            stg_dn   <= '0;
                        end else begin
                            stg_up <= chart_data[3:2];
                            stg_dn <= chart_data[1:0];
                        end
                    end else if (tick) begin
                        pending <= 1'b1;
                    end
                end
                S_WAIT_TICK: if (pending || tick) pending <= 1'b0;
                S_SHIFT: begin
                    up0     <= up0_sh;
                    up1     <= up1_sh;
                    dn0     <= dn0_sh;
                    dn1     <= dn1_sh;
                    pending <= tick;
                    if (addr != ADDR_MAX) addr <= addr + 1'b1;
                    if (end_now) begin
                        end_seen <= 1'b1;
                        stg_up   <= '0;
                        stg_dn   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign chart_req     = (state == S_FETCH);
    assign chart_addr    = addr;
    assign noteup_bit0   = up0;
    assign noteup_bit1   = up1;
    assign notedown_bit0 = dn0;
    assign notedown_bit1 = dn1;
    assign head_valid    = (state == S_SHIFT);
    assign head_up       = head_valid ? {up1[0], up0[0]} : 2'b00;
    assign head_down     = head_valid ? {dn1[0], dn0[0]} : 2'b00;
    assign busy          = running;
    assign done          = (state == S_DONE);
    assign underrun      = underrun_q;

endmodule

// File: tb/tb_note_track_scheduler.sv
// Bench for note_track_scheduler: chart runs against a window model of the scrolling field,
// plus late-ack, pause, ignored-start, mid-fetch reset and address-saturation scenarios.
module tb_note_track_scheduler;
    localparam int COLS     = 16;
    localparam int TICK_DIV = 4;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        start = 1'b0, pause = 1'b0, chart_ack = 1'b0;
    logic [4:0]  chart_data = '0;
    logic        chart_req;
    logic [9:0]  chart_addr;
    logic [15:0] noteup_bit0, noteup_bit1, notedown_bit0, notedown_bit1;
    logic        head_valid, busy, done, underrun;
    logic [1:0]  head_up, head_down;

    logic        start_s = 1'b0, pause_s = 1'b0, chart_ack_s = 1'b0;
    logic [4:0]  chart_data_s = '0;
    logic        chart_req_s;
    logic [2:0]  chart_addr_s;
    logic [15:0] up0_s, up1_s, dn0_s, dn1_s;
    logic        head_valid_s, busy_s, done_s, underrun_s;
    logic [1:0]  head_up_s, head_down_s;

    int checks = 0, errors = 0;
    logic [4:0] chart_mem [0:1023];
    int mem_en = 1, ack_lat = 0, wait_cnt = 0, cur_n = 0;
    int fetch_log[$];

    note_track_scheduler #(.COLS(COLS), .TICK_DIV(TICK_DIV), .ADDR_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause),
        .chart_req(chart_req), .chart_addr(chart_addr), .chart_ack(chart_ack), .chart_data(chart_data),
        .noteup_bit0(noteup_bit0), .noteup_bit1(noteup_bit1),
        .notedown_bit0(notedown_bit0), .notedown_bit1(notedown_bit1),
        .head_valid(head_valid), .head_up(head_up), .head_down(head_down),
        .busy(busy), .done(done), .underrun(underrun));

    note_track_scheduler #(.COLS(COLS), .TICK_DIV(TICK_DIV), .ADDR_W(3)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .pause(pause_s),
        .chart_req(chart_req_s), .chart_addr(chart_addr_s), .chart_ack(chart_ack_s), .chart_data(chart_data_s),
        .noteup_bit0(up0_s), .noteup_bit1(up1_s), .notedown_bit0(dn0_s), .notedown_bit1(dn1_s),
        .head_valid(head_valid_s), .head_up(head_up_s), .head_down(head_down_s),
        .busy(busy_s), .done(done_s), .underrun(underrun_s));

    always #5 clk = ~clk;

    // Chart memory: acks ack_lat cycles after seeing chart_req, logs every accepted address.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_en != 0) begin
                if (chart_ack) begin
                    chart_ack = 1'b0;
                    wait_cnt  = 0;
                end else if (chart_req) begin
                    if (wait_cnt >= ack_lat) begin
                        chart_ack  = 1'b1;
                        chart_data = chart_mem[chart_addr];
                        fetch_log.push_back(int'(chart_addr));
                    end else begin
                        wait_cnt++;
                    end
                end else begin
                    wait_cnt = 0;
                end
            end
        end
    end

    // Column c after k scroll steps holds chart entry k-COLS+c, if that entry exists.
    function automatic logic [1:0] win_code(input int k, input int c, input bit lane_up);
        int j;
        j = k - COLS + c;
        if (j < 0 || j >= cur_n) return 2'b00;
        return lane_up ? chart_mem[j][3:2] : chart_mem[j][1:0];
    endfunction

    function automatic logic [4*COLS-1:0] win_planes(input int k);
        logic [COLS-1:0] u0, u1, d0, d1;
        logic [1:0] cu, cd;
        u0 = '0; u1 = '0; d0 = '0; d1 = '0;
        for (int c = 0; c < COLS; c++) begin
            cu = win_code(k, c, 1'b1);
            cd = win_code(k, c, 1'b0);
            u0[c] = cu[0]; u1[c] = cu[1]; d0[c] = cd[0]; d1[c] = cd[1];
        end
        return {u1, u0, d1, d0};
    endfunction

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic run_chart(input int n, input int lat);
        int step, k_exp, last_hv, bad;
        bit fin;
        logic [4*COLS-1:0] exp_pl;
        logic [3:0] exp_head;
        cur_n = n; ack_lat = lat; mem_en = 1;
        k_exp = n + 1;
        while (win_planes(k_exp) != '0) k_exp++;
        fetch_log.delete();
        pulse_start();
        step = 0; last_hv = -1; fin = 0;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            @(posedge clk); #1;
            if (head_valid) begin
                step++;
                exp_pl   = win_planes(step - 1);
                exp_head = {win_code(step - 1, 0, 1'b1), win_code(step - 1, 0, 1'b0)};
                checks++;
                if ({noteup_bit1, noteup_bit0, notedown_bit1, notedown_bit0} !== exp_pl) begin
                    errors++;
                    $display("FAIL planes n=%0d step %0d: got %h want %h", n, step,
                             {noteup_bit1, noteup_bit0, notedown_bit1, notedown_bit0}, exp_pl);
                end
                checks++;
                if ({head_up, head_down} !== exp_head) begin
                    errors++;
                    $display("FAIL head n=%0d step %0d: got %h want %h", n, step, {head_up, head_down}, exp_head);
                end
                if (last_hv >= 0) begin
                    checks++;
                    if (cyc - last_hv != TICK_DIV) begin
                        errors++;
                        $display("FAIL step_period n=%0d step %0d: got %0d want %0d", n, step, cyc - last_hv, TICK_DIV);
                    end
                end
                last_hv = cyc;
            end
            if (done) fin = 1;
        end
        checks++;
        if (!fin) begin errors++; $display("FAIL run_timeout n=%0d: done got 0 want 1", n); end
        checks++;
        if (step != k_exp) begin errors++; $display("FAIL step_count n=%0d: got %0d want %0d", n, step, k_exp); end
        checks++;
        if ({noteup_bit1, noteup_bit0, notedown_bit1, notedown_bit0, underrun, busy} !== '0) begin
            errors++;
            $display("FAIL done_state n=%0d: planes/underrun/busy nonzero, underrun %0b busy %0b", n, underrun, busy);
        end
        bad = (fetch_log.size() != n + 1) ? 1 : 0;
        foreach (fetch_log[i]) if (fetch_log[i] != i) bad = 1;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL fetch_order n=%0d: got %0d fetches first %0d want %0d from 0", n, fetch_log.size(),
                     (fetch_log.size() > 0) ? fetch_log[0] : -1, n + 1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({chart_req, chart_addr, noteup_bit0, noteup_bit1, notedown_bit0, notedown_bit1,
             head_valid, head_up, head_down, busy, done, underrun} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req %0b addr %0d busy %0b done %0b", chart_req, chart_addr, busy, done);
        end
        checks++;
        if ({chart_req_s, chart_addr_s, up0_s, up1_s, dn0_s, dn1_s, head_valid_s, busy_s, done_s, underrun_s} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_sat: req %0b addr %0d busy %0b", chart_req_s, chart_addr_s, busy_s);
        end
        rst_n = 1'b1;
    endtask

    task automatic load_directed();
        chart_mem[0] = 5'b00100;
        chart_mem[1] = 5'b01000;
        chart_mem[2] = 5'b01100;
        chart_mem[3] = 5'b10000;
    endtask

    task automatic test_directed_chart();
        load_directed();
        run_chart(3, 0);
    endtask

    task automatic test_random_charts();
        int n;
        for (int it = 0; it < 5; it++) begin
            n = (it == 0) ? 0 : $urandom_range(1, 12);
            for (int i = 0; i < n; i++) chart_mem[i] = {1'b0, 4'($urandom)};
            chart_mem[n] = 5'b10000;
            run_chart(n, $urandom_range(0, 2));
        end
    endtask

    task automatic test_pause();
        int hv, bad, cnt;
        bit got;
        logic [4*COLS-1:0] snap;
        cur_n = 40; ack_lat = 0; mem_en = 1;
        for (int i = 0; i < 40; i++) chart_mem[i] = {1'b0, 2'($urandom_range(1, 3)), 2'($urandom)};
        chart_mem[40] = 5'b10000;
        pulse_start();
        hv = 0;
        for (int cyc = 0; cyc < 200 && hv < 3; cyc++) begin
            @(posedge clk); #1;
            if (head_valid) hv++;
        end
        checks++;
        if (hv != 3) begin errors++; $display("FAIL pause_reach_step: got %0d want 3", hv); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (chart_req !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL pause_wait_state: req %0b busy %0b want 0 1", chart_req, busy);
        end
        pause = 1'b1;
        snap = {noteup_bit1, noteup_bit0, notedown_bit1, notedown_bit0};
        checks++;
        if (snap !== win_planes(3)) begin errors++; $display("FAIL pause_snapshot: got %h want %h", snap, win_planes(3)); end
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (head_valid || {noteup_bit1, noteup_bit0, notedown_bit1, notedown_bit0} !== snap) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL pause_frozen: got %0d changed cycles want 0", bad); end
        pause = 1'b0;
        cnt = 0; got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk); #1;
            cnt++;
            if (head_valid) got = 1;
        end
        checks++;
        if (!got || cnt != 2) begin errors++; $display("FAIL pause_residual: got step after %0d cycles want 2", cnt); end
        got = 0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(posedge clk); #1;
            if (done) got = 1;
        end
        checks++;
        if (!got) begin errors++; $display("FAIL pause_done: done got 0 want 1"); end
    endtask

    task automatic test_start_ignored();
        int hv, bad;
        bit got;
        logic [4*COLS-1:0] snap;
        cur_n = 10; ack_lat = 0; mem_en = 1;
        for (int i = 0; i < 10; i++) chart_mem[i] = {1'b0, 2'($urandom_range(1, 3)), 2'($urandom)};
        chart_mem[10] = 5'b10000;
        fetch_log.delete();
        pulse_start();
        hv = 0;
        for (int cyc = 0; cyc < 200 && hv < 2; cyc++) begin
            @(posedge clk); #1;
            if (head_valid) hv++;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        snap = {noteup_bit1, noteup_bit0, notedown_bit1, notedown_bit0};
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({noteup_bit1, noteup_bit0, notedown_bit1, notedown_bit0} !== snap || busy !== 1'b1 || chart_req !== 1'b0) begin
            errors++; $display("FAIL start_wait_ignored: planes %h want %h busy %0b", {noteup_bit1, noteup_bit0}, snap, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (head_valid !== 1'b1) begin errors++; $display("FAIL start_wait_step: head_valid got %0b want 1", head_valid); end
        got = 0;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(posedge clk); #1;
            if (done) got = 1;
        end
        bad = (fetch_log.size() != 11) ? 1 : 0;
        foreach (fetch_log[i]) if (fetch_log[i] != i) bad = 1;
        checks++;
        if (!got || bad != 0) begin
            errors++; $display("FAIL start_wait_order: done %0b fetches %0d want 11 in order", got, fetch_log.size());
        end
    endtask

    task automatic test_late_ack_reset();
        int bad;
        load_directed();
        mem_en = 0;
        chart_ack = 1'b0;
        pulse_start();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            if (chart_req !== 1'b1 || chart_addr !== 10'd0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL late_req_stable: got %0d unstable cycles want 0", bad); end
        chart_ack = 1'b1;
        chart_data = chart_mem[0];
        @(posedge clk); #1;
        chart_ack = 1'b0;
        checks++;
        if (head_valid !== 1'b1 || chart_req !== 1'b0) begin
            errors++; $display("FAIL late_shift_next: head_valid %0b req %0b want 1 0", head_valid, chart_req);
        end
        checks++;
        if (underrun !== 1'b1) begin errors++; $display("FAIL late_underrun: got %0b want 1", underrun); end
        @(posedge clk); #1;
        checks++;
        if (noteup_bit0 !== 16'h8000 || noteup_bit1 !== 16'h0000 || chart_req !== 1'b1 || chart_addr !== 10'd1) begin
            errors++;
            $display("FAIL late_after_shift: up0 %h up1 %h req %0b addr %0d want 8000 0000 1 1",
                     noteup_bit0, noteup_bit1, chart_req, chart_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({chart_req, noteup_bit0, noteup_bit1, notedown_bit0, notedown_bit1, underrun, busy, head_valid} !== '0) begin
            errors++;
            $display("FAIL reset_mid_fetch: req %0b up0 %h underrun %0b busy %0b want all 0", chart_req, noteup_bit0, underrun, busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_cnt = 0;
        mem_en = 1;
        run_chart(3, 0);
    endtask

    task automatic test_saturation();
        int hv, h1, fetches, last_addr;
        bit fin;
        hv = 0; h1 = 0; fetches = 0; last_addr = -1; fin = 0;
        @(negedge clk); start_s = 1'b1;
        @(negedge clk); start_s = 1'b0;
        for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
            @(negedge clk);
            if (head_valid_s) begin
                hv++;
                if (head_up_s == 2'd1 && head_down_s == 2'd1) h1++;
            end
            if (done_s) fin = 1;
            chart_ack_s  = chart_req_s && !chart_ack_s;
            chart_data_s = 5'b00101;
            if (chart_ack_s) begin fetches++; last_addr = int'(chart_addr_s); end
        end
        chart_ack_s = 1'b0;
        checks++;
        if (!fin) begin errors++; $display("FAIL sat_done: done got 0 want 1"); end
        checks++;
        if (fetches != 7 || last_addr != 6) begin
            errors++; $display("FAIL sat_fetches: got %0d last %0d want 7 last 6", fetches, last_addr);
        end
        checks++;
        if (hv != 7 + COLS || h1 != 7) begin
            errors++; $display("FAIL sat_steps: got %0d steps %0d heads want %0d steps 7 heads", hv, h1, 7 + COLS);
        end
        checks++;
        if (chart_addr_s !== 3'd7 || {up0_s, up1_s, dn0_s, dn1_s} !== '0) begin
            errors++; $display("FAIL sat_final: addr %0d want 7, planes nonzero", chart_addr_s);
        end
    endtask

    initial begin
        test_reset();
        test_directed_chart();
        test_random_charts();
        test_pause();
        test_start_ignored();
        test_late_ack_reset();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
